cordic_vectoring: RTL and testbench

- Iterative CORDIC in vectoring mode. It is the inverse of cordic_rotator: it takes a Cartesian vector (Xin, Yin) and returns its polar form.
- Outputs are the gain-scaled magnitude and the phase angle, using the same 32-bit angle format as cordic_rotator (2^32 = 360 degrees).
- Used for phase/magnitude recovery of rotator outputs and for loopback checks of the rotator.

---
 rtl/cordic_vectoring.sv | 164 ++++++++++++++++
 tb/tb_cordic_vectoring.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: converts a signed Cartesian vector (Xin, Yin)
// into gain-scaled magnitude and a 32-bit phase (2^32 = one full turn).
module cordic_vectoring #(
  parameter int SZ   = 16,
  parameter int ITER = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic signed [SZ-1:0] Xin,
  input  logic signed [SZ-1:0] Yin,
  output logic                 busy,
  output logic                 done,
  output logic [SZ:0]          magnitude,
  output logic [31:0]          angle,
  output logic [1:0]           state_dbg
);

  // Handshake: start (with Xin/Yin) is accepted only in IDLE; busy is high from the
  // cycle after acceptance until the result cycle, where done pulses for one cycle
  // and magnitude/angle become valid and hold until the next result or reset.

  localparam int XW = SZ + 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ITERATE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic signed [XW-1:0] x_q, x_d, y_q, y_d;
  logic [31:0]         z_q, z_d;
  logic [4:0]          i_q, i_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic [SZ:0]         mag_q, mag_d;
  logic [31:0]         ang_q, ang_d;

  logic signed [XW-1:0] xin_e, yin_e, x_sh, y_sh;
  logic [31:0]         atan_i;

  function automatic logic [31:0] atan_rom(input logic [4:0] idx);
    case (idx)
      5'd0:    atan_rom = 32'h2000_0000;
      5'd1:    atan_rom = 32'h12E4_051E;
      5'd2:    atan_rom = 32'h09FB_385B;
      5'd3:    atan_rom = 32'h0511_11D4;
      5'd4:    atan_rom = 32'h028B_0D43;
      5'd5:    atan_rom = 32'h0145_D7E1;
      5'd6:    atan_rom = 32'h00A2_F61E;
      5'd7:    atan_rom = 32'h0051_7C55;
      5'd8:    atan_rom = 32'h0028_BE53;
      5'd9:    atan_rom = 32'h0014_5F2F;
      5'd10:   atan_rom = 32'h000A_2F98;
      5'd11:   atan_rom = 32'h0005_17CC;
      5'd12:   atan_rom = 32'h0002_8BE6;
      5'd13:   atan_rom = 32'h0001_45F3;
      5'd14:   atan_rom = 32'h0000_A2FA;
      5'd15:   atan_rom = 32'h0000_517D;
      5'd16:   atan_rom = 32'h0000_28BE;
      5'd17:   atan_rom = 32'h0000_145F;
      5'd18:   atan_rom = 32'h0000_0A30;
      5'd19:   atan_rom = 32'h0000_0518;
      5'd20:   atan_rom = 32'h0000_028C;
      5'd21:   atan_rom = 32'h0000_0146;
      5'd22:   atan_rom = 32'h0000_00A3;
      5'd23:   atan_rom = 32'h0000_0051;
      default: atan_rom = 32'h0000_0000;
    endcase
  endfunction

  assign xin_e  = {{2{Xin[SZ-1]}}, Xin};
  assign yin_e  = {{2{Yin[SZ-1]}}, Yin};
  assign x_sh   = x_q >>> i_q;
  assign y_sh   = y_q >>> i_q;
  assign atan_i = atan_rom(i_q);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    i_d     = i_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    mag_d   = mag_q;
    ang_d   = ang_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          // Fold the left half-plane into the right so iteration starts with x >= 0.
          if (!Xin[SZ-1]) begin
            x_d = xin_e;
            y_d = yin_e;
            z_d = 32'h0000_0000;
          end else if (!Yin[SZ-1]) begin
            x_d = yin_e;
            y_d = -xin_e;
            z_d = 32'h4000_0000;
          end else begin
            x_d = -yin_e;
            y_d = xin_e;
            z_d = 32'hC000_0000;
          end
          i_d     = 5'd0;
          busy_d  = 1'b1;
          state_d = ITERATE;
        end
      end
      ITERATE: begin
        if (!y_q[XW-1]) begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_i;
        end else begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_i;
        end
        i_d = i_q + 5'd1;
        if (i_q == 5'(ITER - 1)) state_d = DONE;
      end
      DONE: begin
        mag_d   = x_q[SZ:0];
        ang_d   = z_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mag_q   <= '0;
      ang_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      i_q     <= i_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mag_q   <= mag_d;
      ang_q   <= ang_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign magnitude = mag_q;
  assign angle     = ang_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Bench for cordic_vectoring: vector table, degree sweep and random vectors against a
// floating-point polar model, plus timing, busy-drop, back-to-back and reset sequences.
module tb_cordic_vectoring;

  localparam int SZ   = 16;
  localparam int ITER = 16;
  localparam int LAT  = ITER + 1;
  localparam longint ANG_TOL = 64'h20000;
  localparam longint MAG_TOL = 10;
  localparam real PI = 3.14159265358979323846;

  logic                 clock;
  logic                 reset;
  logic                 start;
  logic signed [SZ-1:0] Xin, Yin;
  logic                 busy, done;
  logic [SZ:0]          magnitude;
  logic [31:0]          angle;
  logic [1:0]           state_dbg;

  int checks = 0;
  int errors = 0;

  cordic_vectoring #(.SZ(SZ), .ITER(ITER)) dut (
    .clock(clock), .reset(reset), .start(start), .Xin(Xin), .Yin(Yin),
    .busy(busy), .done(done), .magnitude(magnitude), .angle(angle),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic real cordic_gain();
    real k = 1.0;
    for (int i = 0; i < ITER; i++) k = k * $sqrt(1.0 + 2.0 ** (-2.0 * i));
    return k;
  endfunction

  function automatic logic [31:0] turns_to_ang(input real turns);
    real u = turns * 4294967296.0;
    while (u < 0.0) u = u + 4294967296.0;
    while (u >= 4294967296.0) u = u - 4294967296.0;
    return 32'(longint'(u));
  endfunction

  function automatic logic [31:0] ref_angle(input int x, input int y);
    return turns_to_ang($atan2(real'(y), real'(x)) / (2.0 * PI));
  endfunction

  function automatic longint ref_mag(input int x, input int y);
    real r = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
    return longint'($floor(cordic_gain() * r));
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk_eq(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_tol(input string name, input longint act, input longint exp,
                         input longint tol);
    longint d = act - exp;
    checks++;
    if (d < 0) d = -d;
    if (d > tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  task automatic chk_ang(input string name, input logic [31:0] act, input logic [31:0] exp);
    logic [31:0] diff = act - exp;
    int sd;
    longint ad;
    sd = diff;
    ad = sd;
    if (ad < 0) ad = -ad;
    checks++;
    if (ad > ANG_TOL) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h +/- 0x%0h", name, act, exp, ANG_TOL);
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_job(input int x, input int y, output logic [SZ:0] m,
                        output logic [31:0] a, output int lat);
    @(negedge clock);
    Xin   = 16'(x);
    Yin   = 16'(y);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    chk_eq("busy_after_accept", longint'(busy), 1);
    lat = 0;
    m   = '0;
    a   = '0;
    while (lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
      if (done) begin
        m = magnitude;
        a = angle;
        chk_eq("busy_at_done", longint'(busy), 0);
        break;
      end
    end
    @(posedge clock);
    #1;
    chk_eq("done_single_cycle", longint'(done), 0);
  endtask

  typedef struct {
    int          x;
    int          y;
    bit          use_ang;
    logic [31:0] ang;
    longint      mag;
  } vec_t;

  vec_t         tbl[10];
  logic [SZ:0]  m;
  logic [31:0]  a;
  int           lat;
  int           nd;
  int           t_done[3];

  initial begin
    tbl[0] = '{x: 10000,  y: 0,      use_ang: 1'b1, ang: 32'h0000_0000, mag: 16467};
    tbl[1] = '{x: 10000,  y: 10000,  use_ang: 1'b1, ang: 32'h2000_0000, mag: 23288};
    tbl[2] = '{x: 0,      y: 10000,  use_ang: 1'b1, ang: 32'h4000_0000, mag: 16467};
    tbl[3] = '{x: -10000, y: 0,      use_ang: 1'b1, ang: 32'h8000_0000, mag: 16467};
    tbl[4] = '{x: 0,      y: -10000, use_ang: 1'b1, ang: 32'hC000_0000, mag: 16467};
    tbl[5] = '{x: -32768, y: 0,      use_ang: 1'b1, ang: 32'h8000_0000, mag: 53961};
    tbl[6] = '{x: 0,      y: -32768, use_ang: 1'b1, ang: 32'hC000_0000, mag: 53961};
    tbl[7] = '{x: -32768, y: -32768, use_ang: 1'b1, ang: 32'hA000_0000, mag: 76311};
    tbl[8] = '{x: -10000, y: 10000,  use_ang: 1'b1, ang: 32'h6000_0000, mag: 23288};
    tbl[9] = '{x: 0,      y: 0,      use_ang: 1'b0, ang: 32'h0000_0000, mag: 0};

    reset = 1'b1;
    start = 1'b0;
    Xin   = '0;
    Yin   = '0;
    repeat (3) @(posedge clock);
    #1;
    chk_eq("reset_busy", longint'(busy), 0);
    chk_eq("reset_done", longint'(done), 0);
    @(negedge clock);
    reset = 1'b0;

    // Idle after reset
    for (int c = 0; c < 10; c++) begin
      @(posedge clock);
      #1;
      chk_eq("idle_busy", longint'(busy), 0);
      chk_eq("idle_done", longint'(done), 0);
      chk_eq("idle_mag", longint'(magnitude), 0);
      chk_eq("idle_angle", longint'(angle), 0);
    end

    // Directed table
    for (int k = 0; k < 10; k++) begin
      do_job(tbl[k].x, tbl[k].y, m, a, lat);
      chk_eq("tbl_latency", lat, LAT);
      if (tbl[k].use_ang) chk_ang("tbl_angle", a, tbl[k].ang);
      chk_tol("tbl_mag", longint'(m), tbl[k].mag, MAG_TOL);
    end

    // Degree sweep on a radius-19000 circle
    for (int k = 0; k < 360; k++) begin
      int x, y;
      x = int'($floor(19000.0 * $cos(k * PI / 180.0) + 0.5));
      y = int'($floor(19000.0 * $sin(k * PI / 180.0) + 0.5));
      do_job(x, y, m, a, lat);
      chk_eq("sweep_latency", lat, LAT);
      chk_ang("sweep_angle", a, turns_to_ang(real'(k) / 360.0));
      chk_tol("sweep_mag", longint'(m), ref_mag(x, y), MAG_TOL);
    end

    // Random vectors away from the origin
    for (int n = 0; n < 60; n++) begin
      int x, y;
      x = 12000;
      y = 0;
      for (int tries = 0; tries < 100; tries++) begin
        x = int'($urandom_range(65535)) - 32768;
        y = int'($urandom_range(65535)) - 32768;
        if (real'(x) * real'(x) + real'(y) * real'(y) >= 144.0e6) break;
      end
      do_job(x, y, m, a, lat);
      chk_eq("rand_latency", lat, LAT);
      chk_ang("rand_angle", a, ref_angle(x, y));
      chk_tol("rand_mag", longint'(m), ref_mag(x, y), MAG_TOL);
    end

    // Second start while busy is dropped
    @(negedge clock);
    Xin   = 16'sd10000;
    Yin   = 16'sd0;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    nd = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 5) begin
        Xin   = 16'sd0;
        Yin   = 16'sd10000;
        start = 1'b1;
      end
      @(posedge clock);
      #1;
      if (c == 5) start = 1'b0;
      if (done) begin
        nd++;
        m = magnitude;
        a = angle;
        if (nd == 1) chk_eq("drop_latency", c, LAT);
      end
    end
    chk_eq("drop_done_count", nd, 1);
    chk_ang("drop_angle", a, 32'h0000_0000);
    chk_tol("drop_mag", longint'(m), 16467, MAG_TOL);

    // Start raised only in the DONE cycle is ignored
    @(negedge clock);
    Xin   = 16'sd5000;
    Yin   = 16'sd5000;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (ITER) @(posedge clock);
    #1;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    chk_eq("donecyc_done", longint'(done), 1);
    chk_ang("donecyc_angle", angle, 32'h2000_0000);
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clock);
      #1;
      if (done || busy) nd++;
    end
    chk_eq("donecyc_no_restart", nd, 0);

    // Start held high: one result every ITER+2 cycles
    @(negedge clock);
    Xin   = -16'sd20000;
    Yin   = 16'sd3000;
    start = 1'b1;
    nd = 0;
    for (int c = 1; c <= 80 && nd < 3; c++) begin
      @(posedge clock);
      #1;
      if (done) begin
        t_done[nd] = c;
        nd++;
      end
    end
    @(negedge clock);
    start = 1'b0;
    chk_eq("b2b_count", nd, 3);
    if (nd == 3) begin
      chk_eq("b2b_first", t_done[0], LAT + 1);
      chk_eq("b2b_gap1", t_done[1] - t_done[0], ITER + 2);
      chk_eq("b2b_gap2", t_done[2] - t_done[1], ITER + 2);
    end
    chk_ang("b2b_angle", angle, ref_angle(-20000, 3000));
    for (int c = 0; c < 40 && busy; c++) @(posedge clock);

    // Reset in the middle of an operation
    @(negedge clock);
    Xin   = 16'sd20000;
    Yin   = 16'sd5000;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clock);
    #1;
    chk_eq("pre_abort_busy", longint'(busy), 1);
    reset = 1'b1;
    #1;
    chk_eq("abort_busy", longint'(busy), 0);
    chk_eq("abort_done", longint'(done), 0);
    chk_eq("abort_mag", longint'(magnitude), 0);
    chk_eq("abort_angle", longint'(angle), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    nd = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clock);
      #1;
      if (done) nd++;
    end
    chk_eq("abort_no_done", nd, 0);
    do_job(3000, -4000, m, a, lat);
    chk_eq("post_reset_latency", lat, LAT);
    chk_ang("post_reset_angle", a, ref_angle(3000, -4000));
    chk_tol("post_reset_mag", longint'(m), ref_mag(3000, -4000), MAG_TOL);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
